// File: rtl/serial_tx_ctrl.sv
// One-wire UART-style transmitter: latches a byte on a trigger rising edge and
// sends start bit, NBITS data bits (selectable order) and stop bit.
module serial_tx_ctrl #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int NBITS        = 8
) (
   input  logic             clk_100mhz,
   input  logic             rst_n,
   input  logic             trigger,
   input  logic [NBITS-1:0] data,
   input  logic             big_endian,
   output logic             data_out,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state_dbg
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(NBITS - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

   state_t           state, state_n;
   logic [BW-1:0]    baud_cnt, baud_n;
   logic [CW-1:0]    bit_cnt, bit_n;
   logic [NBITS-1:0] shift, shift_n, data_rev;
   logic [NBITS:0]   shift_fill;
   logic             trig_q, rise;
   logic             data_out_n, busy_n, done_n;

   assign rise       = trigger & ~trig_q;
   assign shift_fill = {1'b1, shift};
   assign state_dbg  = state;

   always_comb begin
      data_rev = '0;
      for (int i = 0; i < NBITS; i++) data_rev[i] = data[NBITS-1-i];
   end

   always_comb begin
      state_n = state;
      baud_n  = baud_cnt;
      bit_n   = bit_cnt;
      shift_n = shift;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               state_n = START;
               baud_n  = '0;
               bit_n   = '0;
               shift_n = big_endian ? data_rev : data;
            end
         end
         START: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_n  = '0;
               state_n = DATA;
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            // bit 0 of the shift register is always the bit currently on the line
            if (baud_cnt == BAUD_LAST) begin
               baud_n  = '0;
               shift_n = shift_fill[NBITS:1];
               if (bit_cnt == BIT_LAST) begin
                  bit_n   = '0;
                  state_n = STOP;
               end else begin
                  bit_n = bit_cnt + 1'b1;
               end
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_n  = '0;
               state_n = IDLE;
               done_n  = 1'b1;
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      // outputs are registered from the next state so they line up with it
      busy_n     = (state_n != IDLE);
      data_out_n = (state_n == DATA) ? shift_n[0] : (state_n != START);
   end

   always_ff @(posedge clk_100mhz) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '1;
         trig_q   <= 1'b1;
         data_out <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_cnt  <= bit_n;
         shift    <= shift_n;
         trig_q   <= trigger;
         data_out <= data_out_n;
         busy     <= busy_n;
         done     <= done_n;
      end
   end

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Bench for serial_tx_ctrl: directed scenarios plus random traffic, each cycle
// compared against a line-symbol queue model built from the framing rules.
module tb_serial_tx_ctrl;

   localparam int CPB = 4;
   localparam int NB  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          trigger = 1'b0;
   logic [NB-1:0] data = '0;
   logic          big_endian = 1'b0;
   logic          data_out, busy, done;
   logic [1:0]    state_dbg;

   int vectors = 0;
   int miscompares = 0;
   int busy_acc = 0;

   // model: per-cycle expected line symbols of the frame in flight
   logic [0:0] exp_q[$];
   logic       m_trig_prev = 1'b1;
   logic       m_prev_busy = 1'b0;
   logic       exp_out = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;

   serial_tx_ctrl #(.CLKS_PER_BIT(CPB), .NBITS(NB)) dut (
      .clk_100mhz(clk), .rst_n(rst_n), .trigger(trigger), .data(data),
      .big_endian(big_endian), .data_out(data_out), .busy(busy), .done(done),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic push_frame(input logic [NB-1:0] d, input logic be);
      logic b;
      for (int k = 0; k < CPB; k++) exp_q.push_back(1'b0);
      for (int i = 0; i < NB; i++) begin
         b = be ? d[NB-1-i] : d[i];
         for (int k = 0; k < CPB; k++) exp_q.push_back(b);
      end
      for (int k = 0; k < CPB; k++) exp_q.push_back(1'b1);
   endtask

   task automatic model_step();
      logic rise;
      if (!rst_n) begin
         exp_q.delete();
         m_trig_prev = 1'b1;
         m_prev_busy = 1'b0;
         exp_out = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
      end else begin
         rise = trigger && !m_trig_prev;
         m_trig_prev = trigger;
         if (rise && !m_prev_busy) push_frame(data, big_endian);
         if (exp_q.size() > 0) begin
            exp_out = exp_q.pop_front();
            exp_busy = 1'b1; exp_done = 1'b0;
         end else begin
            exp_out = 1'b1; exp_busy = 1'b0; exp_done = m_prev_busy;
         end
         m_prev_busy = exp_busy;
      end
   endtask

   task automatic check_bit(input string tag, input logic act, input logic exp);
      vectors++;
      assert (act === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_int(input string tag, input int act, input int exp);
      vectors++;
      assert (act === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (busy === 1'b1) busy_acc++;
      check_bit("data_out", data_out, exp_out);
      check_bit("busy", busy, exp_busy);
      check_bit("done", done, exp_done);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input logic [NB-1:0] d, input logic be);
      data = d; big_endian = be; trigger = 1'b1;
      tick();
      trigger = 1'b0;
   endtask

   initial begin
      // reset state
      ticks(3);
      rst_n = 1'b1;
      ticks(2);

      // little endian A5
      busy_acc = 0;
      send(8'hA5, 1'b0);
      ticks(49);
      check_int("busy_len_a5", busy_acc, 40);

      // big endian 01, then little endian 01 for contrast
      send(8'h01, 1'b1);
      ticks(45);
      send(8'h01, 1'b0);
      ticks(45);

      // mid-frame re-trigger with FF is ignored
      send(8'h5A, 1'b0);
      ticks(19);
      send(8'hFF, 1'b1);
      ticks(30);

      // trigger held high for 100 cycles gives one frame
      busy_acc = 0;
      data = 8'hC6; big_endian = 1'b1; trigger = 1'b1;
      ticks(100);
      trigger = 1'b0;
      ticks(3);
      check_int("busy_len_held", busy_acc, 40);

      // back-to-back: re-trigger in the done cycle
      busy_acc = 0;
      send(8'hC3, 1'b0);
      for (int i = 0; i < 60 && !exp_done; i++) tick();
      check_bit("b2b_done_seen", done, 1'b1);
      send(8'h3C, 1'b0);
      ticks(39);
      check_int("busy_len_b2b", busy_acc, 80);
      ticks(5);

      // reset during DATA bit 3 with trigger held high across it
      send(8'h96, 1'b0);
      ticks(CPB + 3 * CPB + 1);
      trigger = 1'b1;
      tick();
      rst_n = 1'b0;
      tick();
      check_bit("rst_mid_line", data_out, 1'b1);
      check_bit("rst_mid_busy", busy, 1'b0);
      rst_n = 1'b1;
      ticks(10);
      trigger = 1'b0;
      tick();
      send(8'h6B, 1'b1);
      ticks(45);

      // reset release with trigger already high
      trigger = 1'b1;
      rst_n = 1'b0;
      ticks(2);
      rst_n = 1'b1;
      busy_acc = 0;
      ticks(20);
      check_int("no_frame_after_rst", busy_acc, 0);
      trigger = 1'b0;
      tick();

      // random traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 15) == 0) trigger = ~trigger;
         data = NB'($urandom);
         big_endian = 1'($urandom);
         tick();
      end
      rst_n = 1'b1; trigger = 1'b0;
      ticks(50);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
